// File: rtl/fano_encoder_punct.sv
// Streaming systematic convolutional encoder: differential precoding, per-frame puncturing,
// a fully pipelined parity tree and a credit-controlled first-word-fall-through output FIFO.
module fano_encoder_punct #(
    parameter int           K          = 89,
    parameter logic [K-1:0] G_1_2      = 89'hD354E3267,
    parameter logic [K-1:0] G_3_4      = 89'h87AFC51E7688DDEE,
    parameter logic [K-1:0] G_7_8      = 89'o77663166177600720153763372136,
    parameter int           FIFO_DEPTH = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] i_code_rate,
    input  logic       i_diff_en,
    input  logic       i_vld,
    input  logic       i_sof,
    input  logic       i_data,
    output logic       o_rdy,
    output logic       o_vld,
    input  logic       i_rdy,
    output logic [1:0] o_data,
    output logic [1:0] o_keep,
    output logic       o_sof
);
    localparam int LOG2  = $clog2(K);
    localparam int LAT   = 1 + LOG2;
    localparam int P     = 1 << LOG2;
    localparam int NODES = 2 * P - 1;
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int CW    = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        RATE_1_2 = 2'd0,
        RATE_3_4 = 2'd1,
        RATE_7_8 = 2'd2
    } rate_e;

    typedef struct packed {
        logic       sof;
        logic [1:0] keep;
        logic [1:0] data;
    } beat_t;

    logic [K-2:0]          sr_q, sr_d;
    logic                  dstate_q, dstate_d;
    logic [2:0]            phase_q, phase_d;
    logic [K-1:0]          mask_q, mask_d;
    rate_e                 rate_q, rate_d;
    logic                  diff_q, diff_d;
    logic [NODES-1:0]      tree_q, tree_d;
    logic [LAT-1:0]        vld_q, vld_d, sys_q, sys_d, sof_q, sof_d;
    logic [LAT-1:0][1:0]   keep_q, keep_d;
    beat_t                 mem_q [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d, inflight;

    logic                  acc, sof_acc, d_bit, cur_diff, cur_dstate, push, pop;
    logic [K-2:0]          cur_sr;
    logic [K-1:0]          cur_mask, sr_next;
    logic [2:0]            cur_phase;
    logic [1:0]            keep_cur;
    rate_e                 cur_rate;
    beat_t                 wdata, head;

    // Credit: every accepted beat owns a FIFO slot from accept until pop, so the FIFO cannot overflow.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < LAT; i++) inflight = inflight + CW'(vld_q[i]);
        o_rdy = (count_q + inflight) < DEPTH_C;
    end

    always_comb begin
        // NOTE: every variable gets a default before any conditional logic, so no latch is inferred.
        acc        = i_vld & o_rdy;
        sof_acc    = acc & i_sof;
        cur_rate   = rate_q;
        cur_mask   = mask_q;
        cur_diff   = diff_q;
        cur_sr     = sr_q;
        cur_dstate = dstate_q;
        cur_phase  = phase_q;
        if (sof_acc) begin
            unique case (i_code_rate)
                2'd1:    begin cur_rate = RATE_3_4; cur_mask = G_3_4; end
                2'd2:    begin cur_rate = RATE_7_8; cur_mask = G_7_8; end
                default: begin cur_rate = RATE_1_2; cur_mask = G_1_2; end
            endcase
            cur_diff   = i_diff_en;
            cur_sr     = '0;
            cur_dstate = 1'b0;
            cur_phase  = '0;
        end

        d_bit    = cur_diff ? (i_data ^ cur_dstate) : i_data;
        sr_next  = {cur_sr, d_bit};
        keep_cur = (cur_phase == 3'd0 || cur_rate == RATE_1_2) ? 2'b11 : 2'b01;

        sr_d     = sr_q;
        dstate_d = dstate_q;
        phase_d  = phase_q;
        mask_d   = mask_q;
        rate_d   = rate_q;
        diff_d   = diff_q;
        if (acc) begin
            sr_d     = sr_next[K-2:0];
            dstate_d = cur_diff ? d_bit : 1'b0;
            mask_d   = cur_mask;
            rate_d   = cur_rate;
            diff_d   = cur_diff;
            unique case (cur_rate)
                RATE_3_4: phase_d = (cur_phase == 3'd2) ? 3'd0 : cur_phase + 3'd1;
                RATE_7_8: phase_d = (cur_phase == 3'd6) ? 3'd0 : cur_phase + 3'd1;
                default:  phase_d = 3'd0;
            endcase
        end

        // Leaves at [P-1:0], each tree level packed above the previous one; root is the last node.
        tree_d        = '0;
        tree_d[K-1:0] = sr_next & cur_mask;
        for (int n = P; n < NODES; n++) tree_d[n] = tree_q[2*(n-P)] ^ tree_q[2*(n-P)+1];

        vld_d  = {vld_q[LAT-2:0], acc};
        sys_d  = {sys_q[LAT-2:0], d_bit};
        sof_d  = {sof_q[LAT-2:0], sof_acc};
        keep_d = {keep_q[LAT-2:0], keep_cur};
    end

    assign push  = vld_q[LAT-1];
    assign pop   = o_vld & i_rdy;
    assign wdata = '{sof: sof_q[LAT-1], keep: keep_q[LAT-1], data: {tree_q[NODES-1], sys_q[LAT-1]}};
    assign head  = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(push);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        count_d  = count_q + CW'(push) - CW'(pop);
    end

    assign o_vld  = (count_q != '0);
    assign o_data = o_vld ? head.data : 2'b00;
    assign o_keep = o_vld ? head.keep : 2'b00;
    assign o_sof  = o_vld & head.sof;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            sr_q     <= '0;
            dstate_q <= 1'b0;
            phase_q  <= '0;
            mask_q   <= G_1_2;
            rate_q   <= RATE_1_2;
            diff_q   <= 1'b0;
            vld_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            sr_q     <= sr_d;
            dstate_q <= dstate_d;
            phase_q  <= phase_d;
            mask_q   <= mask_d;
            rate_q   <= rate_d;
            diff_q   <= diff_d;
            vld_q    <= vld_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: datapath and FIFO storage are not reset; valid tags and the FIFO count qualify their contents.
    always_ff @(posedge clk) begin
        tree_q <= tree_d;
        sys_q  <= sys_d;
        sof_q  <= sof_d;
        keep_q <= keep_d;
        if (push) mem_q[wr_ptr_q] <= wdata;
    end
endmodule

// File: tb/tb_fano_encoder_punct.sv
// Scoreboard bench for fano_encoder_punct: stimulus pushes expected beats, a negedge monitor pops and compares.
module tb_fano_encoder_punct;
    localparam int           K     = 89;
    localparam logic [K-1:0] G12   = 89'hD354E3267;
    localparam logic [K-1:0] G34   = 89'h87AFC51E7688DDEE;
    localparam logic [K-1:0] G78   = 89'o77663166177600720153763372136;
    localparam int           DEPTH = 16;

    typedef struct packed {
        logic       sof;
        logic [1:0] keep;
        logic [1:0] data;
    } beat_t;

    logic       clk = 1'b0, reset = 1'b1;
    logic [1:0] i_code_rate = 2'd0;
    logic       i_diff_en = 1'b0, i_vld = 1'b0, i_sof = 1'b0, i_data = 1'b0, i_rdy = 1'b1;
    logic       o_rdy, o_vld, o_sof;
    logic [1:0] o_data, o_keep;

    int    checks = 0, errors = 0, rdy_mode = 0;
    beat_t sb[$], got_q[$];
    beat_t mon_cur, mon_exp, prev_beat;
    logic  prev_stall = 1'b0;
    logic [K-1:0] g12 = G12;

    logic [K-1:0] m_sr, m_mask;
    logic [1:0]   m_rate;
    logic [2:0]   m_phase;
    logic         m_diff, m_dstate;

    fano_encoder_punct #(.K(K), .G_1_2(G12), .G_3_4(G34), .G_7_8(G78), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .i_code_rate(i_code_rate), .i_diff_en(i_diff_en),
        .i_vld(i_vld), .i_sof(i_sof), .i_data(i_data), .o_rdy(o_rdy), .o_vld(o_vld),
        .i_rdy(i_rdy), .o_data(o_data), .o_keep(o_keep), .o_sof(o_sof)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            1:       i_rdy = 1'b0;
            2:       i_rdy = 1'($urandom_range(0, 1));
            default: i_rdy = 1'b1;
        endcase
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_sr = '0; m_mask = G12; m_rate = 2'd0; m_phase = '0; m_diff = 1'b0; m_dstate = 1'b0;
    endtask

    task automatic model_push(input logic sof, input logic data, input logic [1:0] rate, input logic diff);
        logic d;
        logic [K-1:0] nxt;
        beat_t e;
        if (sof) begin
            m_sr = '0; m_dstate = 1'b0; m_phase = '0; m_diff = diff;
            m_rate = (rate == 2'd3) ? 2'd0 : rate;
            m_mask = (m_rate == 2'd1) ? G34 : (m_rate == 2'd2) ? G78 : G12;
        end
        d = m_diff ? (data ^ m_dstate) : data;
        if (m_diff) m_dstate = d;
        nxt = {m_sr[K-2:0], d};
        e.sof = sof;
        e.keep = (m_phase == 3'd0 || m_rate == 2'd0) ? 2'b11 : 2'b01;
        e.data = {^(nxt & m_mask), d};
        m_sr = nxt;
        if (m_rate == 2'd1) m_phase = (m_phase == 3'd2) ? 3'd0 : m_phase + 3'd1;
        else if (m_rate == 2'd2) m_phase = (m_phase == 3'd6) ? 3'd0 : m_phase + 3'd1;
        else m_phase = 3'd0;
        sb.push_back(e);
    endtask

    task automatic send(input logic sof, input logic data, input logic [1:0] rate, input logic diff);
        int waitc;
        @(negedge clk);
        i_vld = 1'b1; i_sof = sof; i_data = data; i_code_rate = rate; i_diff_en = diff;
        waitc = 0;
        while (!o_rdy && waitc < 2000) begin
            @(negedge clk);
            waitc++;
        end
        if (!o_rdy) begin
            checks++; errors++;
            $display("FAIL send_timeout: o_rdy stayed 0 for %0d cycles", waitc);
        end else begin
            model_push(sof, data, rate, diff);
        end
        @(posedge clk);
        #1 i_vld = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        check(name, sb.size(), 0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 reset = 1'b1;
        sb.delete();
        model_reset();
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    always @(negedge clk) begin
        mon_cur = '{sof: o_sof, keep: o_keep, data: o_data};
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) check("hold_stable", {o_vld, mon_cur}, {1'b1, prev_beat});
            if (o_vld && i_rdy) begin
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL stale_beat: got %0h expected no beat at %0t", mon_cur, $time);
                end else begin
                    mon_exp = sb.pop_front();
                    check("beat", mon_cur, mon_exp);
                    got_q.push_back(mon_cur);
                end
            end
            prev_stall = o_vld && !i_rdy;
            prev_beat  = mon_cur;
        end
    end

    initial begin
        int n, cnt;
        int frame_left;
        logic [1:0] rate;
        logic diff;
        beat_t e;
        logic exp_sys [10] = '{1, 1, 1, 0, 1, 1, 0, 1, 0, 1};

        model_reset();
        repeat (2) @(negedge clk);
        check("rst_o_vld", o_vld, 0);
        check("rst_o_data", o_data, 0);
        check("rst_o_keep", o_keep, 0);
        check("rst_o_sof", o_sof, 0);
        check("rst_o_rdy", o_rdy, 1);
        @(posedge clk);
        #1 reset = 1'b0;

        // Impulse response at rate 1/2: parity walks through the generator mask.
        got_q.delete();
        send(1'b1, 1'b1, 2'd0, 1'b0);
        n = 0;
        @(negedge clk);
        while (!o_vld && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("first_vld_latency", n, 8);
        for (int j = 0; j < 95; j++) send(1'b0, 1'b0, 2'd0, 1'b0);
        drain("impulse_drain");
        check("impulse_count", got_q.size(), 96);
        for (int j = 0; j < 96 && j < got_q.size(); j++) begin
            e = '{sof: (j == 0), keep: 2'b11, data: {(j < K) ? g12[j] : 1'b0, (j == 0)}};
            check("impulse_beat", got_q[j], e);
        end

        // Puncturing: non-sof rate changes are ignored, phase restarts at the second sof.
        got_q.delete();
        for (int j = 0; j < 9; j++)  send(j == 0, 1'($urandom_range(0, 1)), (j == 0) ? 2'd1 : 2'd2, 1'b0);
        for (int j = 0; j < 14; j++) send(j == 0, 1'($urandom_range(0, 1)), (j == 0) ? 2'd2 : 2'd1, 1'b0);
        drain("punct_drain");
        check("punct_count", got_q.size(), 23);
        for (int j = 0; j < 23 && j < got_q.size(); j++) begin
            if (j < 9) check("punct_keep_3_4", {got_q[j].sof, got_q[j].keep}, {(j == 0), ((j % 3) == 0) ? 2'b11 : 2'b01});
            else       check("punct_keep_7_8", {got_q[j].sof, got_q[j].keep}, {(j == 9), (((j - 9) % 7) == 0) ? 2'b11 : 2'b01});
        end

        // Differential precoding; diff-enable toggled mid-frame has no effect until next sof.
        got_q.delete();
        send(1'b1, 1'b1, 2'd0, 1'b1);
        send(1'b0, 1'b0, 2'd0, 1'b1);
        send(1'b0, 1'b0, 2'd0, 1'b1);
        send(1'b0, 1'b1, 2'd0, 1'b1);
        send(1'b0, 1'b1, 2'd0, 1'b1);
        send(1'b0, 1'b0, 2'd0, 1'b0);
        send(1'b0, 1'b1, 2'd0, 1'b0);
        send(1'b1, 1'b1, 2'd0, 1'b0);
        send(1'b0, 1'b0, 2'd0, 1'b0);
        send(1'b0, 1'b1, 2'd0, 1'b0);
        drain("diff_drain");
        check("diff_count", got_q.size(), 10);
        for (int j = 0; j < 10 && j < got_q.size(); j++) check("diff_sys", got_q[j].data[0], exp_sys[j]);

        // Code rate 3 behaves as rate 1/2.
        got_q.delete();
        send(1'b1, 1'b1, 2'd3, 1'b0);
        for (int j = 1; j < 12; j++) send(1'b0, 1'b0, 2'd3, 1'b0);
        drain("rate3_drain");
        check("rate3_count", got_q.size(), 12);
        for (int j = 0; j < 12 && j < got_q.size(); j++) begin
            e = '{sof: (j == 0), keep: 2'b11, data: {g12[j], (j == 0)}};
            check("rate3_beat", got_q[j], e);
        end

        // Backpressure: exactly DEPTH beats accepted, then o_rdy holds low.
        rdy_mode = 1;
        repeat (2) @(negedge clk);
        got_q.delete();
        for (int j = 0; j < DEPTH; j++) send(j == 0, 1'((j % 3) == 0), 2'd0, 1'b0);
        @(negedge clk);
        check("bp_rdy_low", o_rdy, 0);
        i_vld = 1'b1; i_sof = 1'b1; i_data = 1'b1;
        cnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (o_rdy) cnt++;
        end
        i_vld = 1'b0;
        check("bp_no_accept", cnt, 0);
        check("bp_vld_held", o_vld, 1);
        rdy_mode = 0;
        drain("bp_drain");
        check("bp_count", got_q.size(), DEPTH);

        // Reset with 4 beats queued and 5 in flight.
        rdy_mode = 1;
        repeat (2) @(negedge clk);
        for (int j = 0; j < 9; j++) send(j == 0, 1'b1, 2'd0, 1'b0);
        repeat (4) @(negedge clk);
        check("pre_rst_vld", o_vld, 1);
        rdy_mode = 0;
        do_reset();
        @(negedge clk);
        check("post_rst_vld", o_vld, 0);
        check("post_rst_rdy", o_rdy, 1);
        check("post_rst_data", {o_sof, o_keep, o_data}, 0);
        cnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (o_vld) cnt++;
        end
        check("post_rst_no_stale", cnt, 0);
        got_q.delete();
        send(1'b0, 1'b1, 2'd2, 1'b1);
        for (int j = 1; j < 12; j++) send(1'b0, 1'b0, 2'd2, 1'b1);
        drain("post_rst_drain");
        check("post_rst_count", got_q.size(), 12);
        for (int j = 0; j < 12 && j < got_q.size(); j++) begin
            e = '{sof: 1'b0, keep: 2'b11, data: {g12[j], (j == 0)}};
            check("post_rst_beat", got_q[j], e);
        end

        // Random frames with random downstream ready against the model.
        rdy_mode = 2;
        frame_left = 0;
        rate = 2'd0;
        diff = 1'b0;
        for (int b = 0; b < 10000; b++) begin
            if (frame_left == 0) begin
                rate = 2'($urandom_range(0, 3));
                diff = 1'($urandom_range(0, 1));
                frame_left = $urandom_range(1, 150);
                send(1'b1, 1'($urandom_range(0, 1)), rate, diff);
            end else begin
                send(1'b0, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
            end
            frame_left--;
            if ($urandom_range(0, 7) == 0) @(negedge clk);
        end
        drain("random_drain");
        rdy_mode = 0;
        got_q.delete();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
